uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-002 SHALL have parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame; legal 1 or 2.
REQ-004 SHALL have clk  input  1  system clock; all logic on posedge clk.
REQ-005 SHALL have reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have baud_clk  input  1  divided clock from the upstream clock divider, generated in the clk domain, square wave.
REQ-007 SHALL have tx_data  input  DATA_BITS  byte to send; sampled only on accept.
REQ-008 SHALL have tx_valid  input  1  producer has tx_data available.
REQ-009 SHALL have tx_ready  output  1  block can accept a word.
REQ-010 SHALL have txd  output  1  serial line, idle high.
REQ-011 SHALL have busy  output  1  frame pending or in progress.

Function
REQ-012 SHALL register baud_clk into baud_q and form tick = baud_clk AND NOT baud_q, a 1-clk pulse per baud_clk rising edge. baud_clk is never used as a clock.
REQ-013 SHALL define one bit period as the interval between consecutive ticks.
REQ-014 SHALL implement the states IDLE, SYNC, START, DATA, PARITY and STOP.
REQ-015 SHALL drive tx_ready = 1 only in IDLE, and busy = 1 in every state except IDLE.
REQ-016 SHALL accept a word on the clk edge where tx_valid=1 and tx_ready=1: latch tx_data into the shift register, compute the parity bit, and go IDLE->SYNC.
REQ-017 SHALL ignore any tick that coincides with the accept edge; the start bit begins no earlier than the next tick.
REQ-018 SHALL, in SYNC, hold txd=1; on tick: state<=START, txd<=0.
REQ-019 SHALL, in START, on tick: state<=DATA, txd<=shift[0] (LSB first), bit counter<=0.
REQ-020 SHALL, in DATA, on tick: shift right and increment the counter.
REQ-021 SHALL, in DATA, drive the next data bit while counter < DATA_BITS-1.
REQ-022 SHALL, after the last DATA bit period, go to PARITY (txd<=parity bit) if PARITY!=0, else go to STOP (txd<=1).
REQ-023 SHALL compute the parity bit so that total ones in data+parity is odd (PARITY=1) or even (PARITY=2).
REQ-024 SHALL, in PARITY, on tick: state<=STOP, txd<=1, stop counter<=0.
REQ-025 SHALL, in STOP, hold txd=1 for STOP_BITS bit periods.
REQ-026 SHALL, on the tick ending the final stop period, go to IDLE.
REQ-027 SHALL always register txd; it changes only on the clk edge where tick=1, except at reset.
REQ-028 SHALL ignore tx_valid and tx_data while tx_ready=0; words are neither queued nor corrupted.
REQ-029 SHALL separate back-to-back frames by at least one idle bit period, the SYNC wait.
REQ-030 SHALL keep its state unchanged if baud_clk stops; txd holds its current level indefinitely.

Reset
REQ-031 SHALL, while reset_n=0, force: state=IDLE, txd=1, baud_q=0, shift register=0, counters=0, tx_ready=1, busy=0.
REQ-032 SHALL, when reset is asserted mid-frame, discard the frame and drive txd=1 immediately (asynchronously).
REQ-033 SHALL start no frame after reset deassertion until a new accept.
REQ-034 SHALL, if baud_clk is already high at reset release, produce one tick on the first clk edge; that tick is harmless in IDLE.

Verification
REQ-035 SHALL be checked by: upstream divider DIVIDER=2 (tick every 4 clk), defaults, send 0x55 -> txd per bit period 0,1,0,1,0,1,0,1,0,1 (start, data LSB first, stop); tx_ready=1 again after the stop period.
REQ-036 SHALL be checked by: PARITY=2, send 0xA5 -> parity bit 0; PARITY=1, send 0xA5 -> parity bit 1; PARITY=1, send 0x01 -> parity bit 0; frame length 11 bit periods.
REQ-037 SHALL be checked by: STOP_BITS=2, send 0x00 -> txd=0 for 9 bit periods, then 1 for exactly 2 bit periods before busy=0.
REQ-038 SHALL be checked by: tx_valid held high with 0x11 then 0x22 -> two frames, each sent exactly once, at least one idle bit period between them; tx_data changed during frame 1 does not alter frame 1.
REQ-039 SHALL be checked by: accept coincident with tick -> start bit (txd=0) appears only at the following tick, not the coincident one.
REQ-040 SHALL be checked by: reset_n pulsed low during data bit 3 -> txd=1 and busy=0 in the same cycle; no further txd transitions until the next accept.

Source files
------------

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - word handshake between a producer and uart_tx
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter paced by baud_clk rising edges detected in the clk domain
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     baud_clk,
    uart_tx_if.slave tx_if,
    output logic     txd,
    output logic     busy
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 baud_q;
    logic                 txd_q, txd_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 tick;

    assign tick           = baud_clk & ~baud_q;
    assign tx_if.tx_ready = (state_q == S_IDLE);
    assign busy           = (state_q != S_IDLE);
    assign txd            = txd_q;

    always_comb begin
        state_d    = state_q;
        txd_d      = txd_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        unique case (state_q)
            // A tick on the accept edge is deliberately ignored; SYNC waits for the next one.
            S_IDLE: begin
                if (tx_if.tx_valid) begin
                    state_d = S_SYNC;
                    shift_d = tx_if.tx_data;
                    par_d   = (PARITY == 1) ? ~(^tx_if.tx_data) : (^tx_if.tx_data);
                end
            end
            S_SYNC: begin
                if (tick) begin
                    state_d = S_START;
                    txd_d   = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d   = S_DATA;
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_cnt_q < 4'(DATA_BITS - 1)) begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (PARITY != 0) begin
                        state_d = S_PARITY;
                        txd_d   = par_q;
                    end else begin
                        state_d    = S_STOP;
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                    end
                end
            end
            S_PARITY: begin
                if (tick) begin
                    state_d    = S_STOP;
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Asynchronous reset drops the line to idle-high immediately, even mid-frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            baud_q     <= 1'b0;
            txd_q      <= 1'b1;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_clk;
            txd_q      <= txd_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across four parity/stop configurations
module tb_uart_tx;
    localparam int NCH = 4;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       baud_clk = 1'b0;
    logic       baud_en  = 1'b0;
    logic [1:0] div_cnt  = 2'd0;
    logic       b1, b2, tick_last;

    logic       txd_w  [NCH];
    logic       busy_w [NCH];
    logic       rdy_w  [NCH];
    logic       vld    [NCH];
    logic [7:0] dat    [NCH];

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q [NCH][$];
    bit          act      [NCH];
    int          pos      [NCH];
    int          idle_cnt [NCH];
    logic [15:0] got      [NCH];
    logic        prev_txd [NCH];
    logic        rst_prev;

    uart_tx_if #(.DATA_BITS(8)) bus0 ();
    uart_tx_if #(.DATA_BITS(8)) bus1 ();
    uart_tx_if #(.DATA_BITS(8)) bus2 ();
    uart_tx_if #(.DATA_BITS(8)) bus3 ();

    assign bus0.tx_valid = vld[0]; assign bus0.tx_data = dat[0]; assign rdy_w[0] = bus0.tx_ready;
    assign bus1.tx_valid = vld[1]; assign bus1.tx_data = dat[1]; assign rdy_w[1] = bus1.tx_ready;
    assign bus2.tx_valid = vld[2]; assign bus2.tx_data = dat[2]; assign rdy_w[2] = bus2.tx_ready;
    assign bus3.tx_valid = vld[3]; assign bus3.tx_data = dat[3]; assign rdy_w[3] = bus3.tx_ready;

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_if(bus0), .txd(txd_w[0]), .busy(busy_w[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_if(bus1), .txd(txd_w[1]), .busy(busy_w[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_if(bus2), .txd(txd_w[2]), .busy(busy_w[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset_n(reset_n), .baud_clk(baud_clk), .tx_if(bus3), .txd(txd_w[3]), .busy(busy_w[3]));

    always #5 clk = ~clk;

    // Upstream divider with DIVIDER=2: baud_clk toggles every 2 clk, one rising edge per 4 clk.
    always @(posedge clk) begin
        if (baud_en) begin
            if (div_cnt == 2'd1) begin
                div_cnt  <= 2'd0;
                baud_clk <= ~baud_clk;
            end else begin
                div_cnt <= div_cnt + 2'd1;
            end
        end
    end

    // b1 is baud_clk as seen at the last edge, b2 the edge before; a rising pair marks a bit boundary.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            b1 <= 1'b0;
            b2 <= 1'b0;
        end else begin
            b1 <= baud_clk;
            b2 <= b1;
        end
    end
    assign tick_last = b1 & ~b2;

    function automatic int par_of(input int c);
        return (c == 1) ? 2 : (c == 2) ? 1 : 0;
    endfunction

    function automatic int flen(input int c);
        return 9 + ((par_of(c) != 0) ? 1 : 0) + ((c == 3) ? 2 : 1);
    endfunction

    // Expected line levels per bit period, LSB = start bit; unused high positions read as idle 1.
    function automatic logic [15:0] frame_bits(input int c, input logic [7:0] d);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[1 + i] = d[i];
        if (par_of(c) == 1) f[9] = (($countones(d) % 2) == 0);
        if (par_of(c) == 2) f[9] = (($countones(d) % 2) == 1);
        return f;
    endfunction

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        n_checks++;
        if (actual !== required) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (reset_n && rst_prev && (txd_w[c] !== prev_txd[c]))
                chk($sformatf("txd_moves_only_on_tick_ch%0d", c), tick_last, 1);
            prev_txd[c] = txd_w[c];
            if (!reset_n) begin
                act[c] = 1'b0;
                exp_q[c].delete();
                idle_cnt[c] = 1;
            end else if (tick_last) begin
                if (!act[c]) begin
                    if (txd_w[c] == 1'b0) begin
                        chk($sformatf("idle_period_before_start_ch%0d", c), idle_cnt[c] >= 1, 1);
                        act[c]    = 1'b1;
                        pos[c]    = 1;
                        got[c]    = '1;
                        got[c][0] = 1'b0;
                    end else begin
                        idle_cnt[c]++;
                    end
                end else if (pos[c] < flen(c)) begin
                    got[c][pos[c]] = txd_w[c];
                    pos[c]++;
                    chk($sformatf("busy_in_frame_ch%0d", c), busy_w[c], 1);
                end else begin
                    chk($sformatf("busy_after_stop_ch%0d", c), busy_w[c], 0);
                    chk($sformatf("ready_after_stop_ch%0d", c), rdy_w[c], 1);
                    if (exp_q[c].size() == 0)
                        chk($sformatf("frame_was_expected_ch%0d", c), exp_q[c].size(), 1);
                    else
                        chk($sformatf("frame_bits_ch%0d", c), got[c], exp_q[c].pop_front());
                    act[c]      = 1'b0;
                    idle_cnt[c] = txd_w[c] ? 1 : 0;
                end
            end
        end
        rst_prev = reset_n;
    end

    task automatic send(input int c, input logic [7:0] d, input bit hold);
        int t;
        t      = 0;
        vld[c] = 1'b1;
        dat[c] = d;
        while (!rdy_w[c] && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("accept_ready_ch%0d", c), rdy_w[c], 1);
        if (!rdy_w[c]) begin
            vld[c] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q[c].push_back(frame_bits(c, d));
        @(negedge clk);
        if (!hold) vld[c] = 1'b0;
    endtask

    task automatic drain();
        int t;
        bit done;
        t    = 0;
        done = 1'b0;
        while (!done && t < 3000) begin
            @(negedge clk);
            t++;
            done = 1'b1;
            for (int c = 0; c < NCH; c++)
                if (exp_q[c].size() != 0 || busy_w[c] || act[c]) done = 1'b0;
        end
        chk("drain_complete", done, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t;
        int         k;
        logic       hold_lvl;
        logic       moved;
        logic [7:0] d;

        for (int c = 0; c < NCH; c++) begin
            vld[c] = 1'b0; dat[c] = 8'h00; act[c] = 1'b0; pos[c] = 0;
            idle_cnt[c] = 1; prev_txd[c] = 1'b1;
        end
        rst_prev = 1'b0;
        reset_n  = 1'b0;
        baud_en  = 1'b1;
        repeat (5) @(negedge clk);
        for (int c = 0; c < NCH; c++) begin
            chk($sformatf("reset_txd_ch%0d", c), txd_w[c], 1);
            chk($sformatf("reset_busy_ch%0d", c), busy_w[c], 0);
            chk($sformatf("reset_ready_ch%0d", c), rdy_w[c], 1);
        end
        #1 reset_n = 1'b1;
        @(negedge clk);

        send(0, 8'h55, 1'b0);
        drain();

        send(1, 8'hA5, 1'b0);
        send(2, 8'hA5, 1'b0);
        send(2, 8'h01, 1'b0);
        send(3, 8'h00, 1'b0);
        drain();

        send(0, 8'h11, 1'b1);
        dat[0] = 8'h22;
        send(0, 8'h22, 1'b0);
        drain();

        t = 0;
        while (!(rdy_w[0] && baud_clk && !b1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("align_to_tick", t < 100, 1);
        vld[0] = 1'b1;
        dat[0] = 8'h3C;
        @(posedge clk);
        exp_q[0].push_back(frame_bits(0, 8'h3C));
        @(negedge clk);
        vld[0] = 1'b0;
        chk("coincident_tick_txd_high", txd_w[0], 1);
        chk("coincident_tick_busy", busy_w[0], 1);
        repeat (3) @(negedge clk);
        chk("start_not_before_next_tick", txd_w[0], 1);
        @(negedge clk);
        chk("start_on_next_tick", txd_w[0], 0);
        drain();

        repeat (40) begin
            k = $urandom_range(0, NCH - 1);
            d = 8'($urandom);
            send(k, d, 1'b0);
            repeat ($urandom_range(0, 6)) @(negedge clk);
        end
        drain();

        send(1, 8'hC3, 1'b0);
        repeat (20) @(negedge clk);
        baud_en  = 1'b0;
        hold_lvl = txd_w[1];
        repeat (40) @(negedge clk);
        chk("stall_txd_holds", txd_w[1], hold_lvl);
        chk("stall_busy_holds", busy_w[1], 1);
        baud_en = 1'b1;
        drain();

        d = 8'($urandom) & 8'hF7;
        send(0, d, 1'b0);
        t = 0;
        while (!(tick_last && txd_w[0] == 1'b0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("start_bit_seen", t < 100, 1);
        k = 0;
        t = 0;
        while (k < 4 && t < 100) begin
            @(negedge clk);
            t++;
            if (tick_last) k++;
        end
        chk("data_bit3_low", txd_w[0], 0);
        #1 reset_n = 1'b0;
        #1;
        chk("async_reset_txd", txd_w[0], 1);
        chk("async_reset_busy", busy_w[0], 0);
        chk("async_reset_ready", rdy_w[0], 1);
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        moved = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (txd_w[0] !== 1'b1 || busy_w[0] !== 1'b0) moved = 1'b1;
        end
        chk("no_frame_after_reset", moved, 0);
        send(0, 8'hE7, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
